// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: the fetch and data requester handshakes plus the shared memory port.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_err_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// one transaction in flight, with a watchdog that forces an error response on a stalled memory.
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    mem_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int             TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             r_state;
    logic               r_ownerD;
    logic               r_lastD;
    logic [TW-1:0]      r_timer;

    logic               r_memReq;
    logic               r_memWe;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [DATA_W-1:0]  r_memWdata;

    logic               r_ifGnt;
    logic               r_ifRvalid;
    logic               r_ifErr;
    logic [DATA_W-1:0]  r_ifRdata;
    logic               r_dGnt;
    logic               r_dRvalid;
    logic               r_dErr;
    logic [DATA_W-1:0]  r_dRdata;

    logic               w_pickD;
    logic               w_timeout;
    logic               w_done;
    logic               w_err;

    // On a tie the port that did not own the bus last time wins
    assign w_pickD   = bus.d_req_i && (!bus.if_req_i || !r_lastD);
    assign w_timeout = (TIMEOUT != 0) && (r_timer == TLAST);

    // A real response in RESP beats a watchdog expiry landing in the same cycle
    always_comb begin
        w_done = 1'b0;
        w_err  = 1'b0;
        if (r_state == RESP && bus.mem_rvalid_i) begin
            w_done = 1'b1;
        end else if (r_state != IDLE && w_timeout) begin
            w_done = 1'b1;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_ownerD   <= 1'b0;
            r_lastD    <= 1'b1;
            r_timer    <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_ifGnt    <= 1'b0;
            r_ifRvalid <= 1'b0;
            r_ifErr    <= 1'b0;
            r_ifRdata  <= '0;
            r_dGnt     <= 1'b0;
            r_dRvalid  <= 1'b0;
            r_dErr     <= 1'b0;
            r_dRdata   <= '0;
        end else begin
            r_ifGnt    <= 1'b0;
            r_dGnt     <= 1'b0;
            r_ifRvalid <= 1'b0;
            r_dRvalid  <= 1'b0;
            r_ifErr    <= 1'b0;
            r_dErr     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        r_state  <= REQ;
                        r_memReq <= 1'b1;
                        r_timer  <= '0;
                        r_ownerD <= w_pickD;
                        r_lastD  <= w_pickD;
                        if (w_pickD) begin
                            r_dGnt     <= 1'b1;
                            r_memWe    <= bus.d_we_i;
                            r_memAddr  <= bus.d_addr_i;
                            r_memWdata <= bus.d_wdata_i;
                        end else begin
                            r_ifGnt    <= 1'b1;
                            r_memWe    <= 1'b0;
                            r_memAddr  <= bus.if_addr_i;
                            r_memWdata <= '0;
                        end
                    end
                end

                REQ, RESP: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_memReq <= 1'b0;
                        // Error responses zero the data; write acks leave the last read data intact
                        if (r_ownerD) begin
                            r_dRvalid <= 1'b1;
                            r_dErr    <= w_err;
                            if (w_err) begin
                                r_dRdata <= '0;
                            end else if (!r_memWe) begin
                                r_dRdata <= bus.mem_rdata_i;
                            end
                        end else begin
                            r_ifRvalid <= 1'b1;
                            r_ifErr    <= w_err;
                            if (w_err) begin
                                r_ifRdata <= '0;
                            end else begin
                                r_ifRdata <= bus.mem_rdata_i;
                            end
                        end
                    end else if (r_state == REQ && bus.mem_gnt_i) begin
                        r_state  <= RESP;
                        r_memReq <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_memReq <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt_o    = r_ifGnt;
    assign bus.if_rvalid_o = r_ifRvalid;
    assign bus.if_rdata_o  = r_ifRdata;
    assign bus.if_err_o    = r_ifErr;
    assign bus.d_gnt_o     = r_dGnt;
    assign bus.d_rvalid_o  = r_dRvalid;
    assign bus.d_rdata_o   = r_dRdata;
    assign bus.d_err_o     = r_dErr;
    assign bus.mem_req_o   = r_memReq;
    assign bus.mem_we_o    = r_memWe;
    assign bus.mem_addr_o  = r_memAddr;
    assign bus.mem_wdata_o = r_memWdata;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios followed by random traffic, with the
// bench acting as the memory and predicting every transaction from the arbitration rules.
module tb_mem_arb;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int NEVER   = 99;

    logic clk_i = 1'b0;
    logic reset_i;

    mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int assertCount = 0;
    int failCount   = 0;

    // Reference state: memory contents, pending requests, last bus owner, last delivered read data
    logic [31:0] memModel [bit [31:0]];
    bit          pendIf;
    bit          pendD;
    bit          lastOwnerD;
    logic [31:0] ifAddr;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        dWe;
    logic [31:0] expIfRdata;
    logic [31:0] expDRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_if_gnt"},    32'(bus.if_gnt_o),    32'd0);
        checkOutput({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 32'd0);
        checkOutput({tag, "_if_err"},    32'(bus.if_err_o),    32'd0);
        checkOutput({tag, "_if_rdata"},  bus.if_rdata_o,       32'd0);
        checkOutput({tag, "_d_gnt"},     32'(bus.d_gnt_o),     32'd0);
        checkOutput({tag, "_d_rvalid"},  32'(bus.d_rvalid_o),  32'd0);
        checkOutput({tag, "_d_err"},     32'(bus.d_err_o),     32'd0);
        checkOutput({tag, "_d_rdata"},   bus.d_rdata_o,        32'd0);
        checkOutput({tag, "_mem_req"},   32'(bus.mem_req_o),   32'd0);
        checkOutput({tag, "_mem_we"},    32'(bus.mem_we_o),    32'd0);
        checkOutput({tag, "_mem_addr"},  bus.mem_addr_o,       32'd0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata_o,      32'd0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus();
        bus.if_req_i  = pendIf;
        bus.if_addr_i = ifAddr;
        bus.d_req_i   = pendD;
        bus.d_we_i    = dWe;
        bus.d_addr_i  = dAddr;
        bus.d_wdata_i = dWdata;
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return ~a;
    endfunction

    task automatic setIf(input logic [31:0] a);
        pendIf = 1'b1;
        ifAddr = a;
    endtask

    task automatic setD(input logic we, input logic [31:0] a, input logic [31:0] wd);
        pendD  = 1'b1;
        dWe    = we;
        dAddr  = a;
        dWdata = wd;
    endtask

    task automatic raiseRequests(input bit wantIf, input bit wantD);
        if (wantIf && !pendIf) setIf(32'($urandom_range(0, 15)) << 2);
        if (wantD && !pendD) setD(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    endtask

    // One full transaction: memory grants after gd wait cycles and answers rd cycles after that.
    // Response arrives gd+rd+2 cycles after the grant unless the watchdog fires first at TIMEOUT.
    task automatic runTxn(input int gd, input int rd, input bit late);
        bit          ownD;
        bit          err;
        int          lat;
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rdv;

        ownD = pendD && (!pendIf || !lastOwnerD);
        a    = ownD ? dAddr : ifAddr;
        we   = ownD ? dWe : 1'b0;
        wd   = ownD ? dWdata : 32'd0;
        lat  = gd + rd + 2;
        err  = 1'b0;
        if (lat > TIMEOUT) begin
            lat = TIMEOUT;
            err = 1'b1;
        end
        rdv = 32'd0;

        applyStimulus();
        tick();
        checkOutput("gnt_if",    32'(bus.if_gnt_o),    32'(!ownD));
        checkOutput("gnt_d",     32'(bus.d_gnt_o),     32'(ownD));
        checkOutput("gnt_mem_req", 32'(bus.mem_req_o), 32'd1);
        checkOutput("gnt_mem_addr",  bus.mem_addr_o,   a);
        checkOutput("gnt_mem_we",    32'(bus.mem_we_o), 32'(we));
        checkOutput("gnt_mem_wdata", bus.mem_wdata_o,  wd);

        lastOwnerD = ownD;
        if (ownD) pendD = 1'b0;
        else pendIf = 1'b0;
        applyStimulus();

        for (int j = 1; j <= lat; j++) begin
            if (ownD) begin
                bus.d_addr_i  = $urandom;
                bus.d_wdata_i = $urandom;
                bus.d_we_i    = 1'($urandom_range(0, 1));
            end else begin
                bus.if_addr_i = $urandom;
            end
            bus.mem_gnt_i    = (j == gd + 1);
            bus.mem_rvalid_i = (j == gd + 2 + rd);
            bus.mem_rdata_i  = $urandom;
            if (j == gd + 1) begin
                rdv = memRead(a);
                if (we) memModel[a] = wd;
            end
            if (j == gd + 2 + rd) bus.mem_rdata_i = rdv;
            tick();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (j < lat) begin
                checkOutput("wait_mem_req", 32'(bus.mem_req_o), 32'(j <= gd));
                if (j <= gd) begin
                    checkOutput("wait_mem_addr",  bus.mem_addr_o,    a);
                    checkOutput("wait_mem_we",    32'(bus.mem_we_o), 32'(we));
                    checkOutput("wait_mem_wdata", bus.mem_wdata_o,   wd);
                end
                checkOutput("wait_quiet",
                            32'({bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o}), 32'd0);
            end
        end

        if (ownD) begin
            if (err) expDRdata = 32'd0;
            else if (!we) expDRdata = rdv;
        end else begin
            expIfRdata = err ? 32'd0 : rdv;
        end
        checkOutput("rsp_if_rvalid", 32'(bus.if_rvalid_o), 32'(!ownD));
        checkOutput("rsp_d_rvalid",  32'(bus.d_rvalid_o),  32'(ownD));
        checkOutput("rsp_if_err",    32'(bus.if_err_o),    32'(!ownD && err));
        checkOutput("rsp_d_err",     32'(bus.d_err_o),     32'(ownD && err));
        checkOutput("rsp_if_rdata",  bus.if_rdata_o,       expIfRdata);
        checkOutput("rsp_d_rdata",   bus.d_rdata_o,        expDRdata);
        checkOutput("rsp_mem_req",   32'(bus.mem_req_o),   32'd0);
        checkOutput("rsp_gnt",       32'({bus.if_gnt_o, bus.d_gnt_o}), 32'd0);

        // A stray memory response while idle must not reach either requester
        if (late) begin
            bus.if_req_i     = 1'b0;
            bus.d_req_i      = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = $urandom;
            tick();
            bus.mem_rvalid_i = 1'b0;
            checkOutput("late_rvalid", 32'({bus.if_rvalid_o, bus.d_rvalid_o}), 32'd0);
            checkOutput("late_if_rdata", bus.if_rdata_o, expIfRdata);
            checkOutput("late_d_rdata",  bus.d_rdata_o,  expDRdata);
            checkOutput("late_mem_req",  32'(bus.mem_req_o), 32'd0);
            applyStimulus();
        end
    endtask

    initial begin
        reset_i          = 1'b1;
        pendIf           = 1'b0;
        pendD            = 1'b0;
        lastOwnerD       = 1'b1;
        ifAddr           = 32'd0;
        dAddr            = 32'd0;
        dWdata           = 32'd0;
        dWe              = 1'b0;
        expIfRdata       = 32'd0;
        expDRdata        = 32'd0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'd0;
        applyStimulus();
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        $display("[TB] Round-robin with both requesters held");
        raiseRequests(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            runTxn(0, 0, 1'b0);
            if (k < 3) raiseRequests(1'b1, 1'b1);
        end

        $display("[TB] Fetch-only best-case read");
        memModel[32'h100] = 32'hDEADBEEF;
        setIf(32'h100);
        runTxn(0, 0, 1'b0);

        $display("[TB] Data write");
        setD(1'b1, 32'h20, 32'h55);
        runTxn(0, 0, 1'b0);

        $display("[TB] Watchdog expiry, late response, then normal read");
        setIf(32'h40);
        runTxn(NEVER, 0, 1'b1);
        setD(1'b0, 32'h20, 32'h0);
        runTxn(0, 1, 1'b0);

        $display("[TB] Stalled grant with changing requester inputs, watchdog boundaries");
        setD(1'b1, 32'h30, 32'hA5A5_5A5A);
        runTxn(2, 0, 1'b0);
        setIf(32'h30);
        runTxn(1, 1, 1'b0);
        setD(1'b0, 32'h30, 32'h0);
        runTxn(2, 1, 1'b1);

        $display("[TB] Asynchronous reset during response wait");
        setIf(32'h44);
        applyStimulus();
        tick();
        checkOutput("rst_pre_gnt", 32'(bus.if_gnt_o), 32'd1);
        pendIf = 1'b0;
        applyStimulus();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        checkOutput("rst_pre_resp_req", 32'(bus.mem_req_o), 32'd0);
        #3;
        reset_i = 1'b1;
        #1;
        checkAllZero("async_reset");
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        tick();
        #2;
        reset_i = 1'b0;
        tick();
        checkOutput("rst_no_rvalid", 32'({bus.if_rvalid_o, bus.d_rvalid_o}), 32'd0);
        checkOutput("rst_if_rdata", bus.if_rdata_o, 32'd0);
        bus.mem_rvalid_i = 1'b0;
        tick();
        checkOutput("rst_no_rvalid2", 32'({bus.if_rvalid_o, bus.d_rvalid_o}), 32'd0);
        lastOwnerD = 1'b1;
        expIfRdata = 32'd0;
        expDRdata  = 32'd0;
        raiseRequests(1'b1, 1'b1);
        runTxn(0, 0, 1'b0);

        $display("[TB] Random traffic");
        for (int n = 0; n < 60; n++) begin
            int pick;
            pick = $urandom_range(1, 3);
            raiseRequests(pick[0], pick[1]);
            runTxn($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        while (pendIf || pendD) runTxn(0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
